data_memory_sized: RTL and testbench

// - Parametrised MIPS data memory with byte/halfword/word access, sign/zero extension, configurable wait states and a ready handshake.
// - Sits in the MEM stage; the pipeline stalls while a request is outstanding.
// - Reports misaligned accesses to the exception logic instead of silently corrupting memory.

---
 rtl/data_memory_sized_if.sv | 25 ++
 rtl/data_memory_sized.sv | 209 ++++++++++++++++++++
 tb/tb_data_memory_sized.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
// The requester drives the master side; the memory implements the slave side.
interface data_memory_sized_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] read_data;
  logic        ready;
  logic        misaligned;
  logic [15:0] read_count;
  logic [15:0] write_count;

  modport master (
    output address, write_data, MemWrite, MemRead, size, sign_ext,
    input  read_data, ready, misaligned, read_count, write_count
  );

  modport slave (
    input  address, write_data, MemWrite, MemRead, size, sign_ext,
    output read_data, ready, misaligned, read_count, write_count
  );
endinterface

// File: rtl/data_memory_sized.sv
// MIPS data memory with byte/half/word access, wait states and a ready pulse.
// Optional access counters are built only when DMEM_ACCESS_COUNT_EN is defined.
module data_memory_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic               clock,
  input logic               reset,
  data_memory_sized_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  function automatic logic is_misaligned(input logic [1:0] lane, input logic [1:0] sz);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      default: r = (lane != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [1:0]    state_r;
  logic [3:0]    wait_cnt_r;
  logic [AW+1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [1:0]    size_r;
  logic          sext_r;
  logic          write_op_r;
  logic [31:0]   read_data_r;
  logic          ready_r;
  logic          misaligned_r;

  logic          req_s;
  logic [AW+1:0] acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic [1:0]    acc_size_s;
  logic          acc_sext_s;
  logic          acc_write_s;
  logic          enter_done_s;
  logic          misaligned_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   mem_word_s;
  logic [31:0]   load_val_s;
  logic [31:0]   store_word_s;
  logic          commit_s;

  assign req_s = bus.MemRead | bus.MemWrite;

  // In IDLE a zero-wait access completes straight from the live inputs; otherwise use the latched request.
  always_comb begin
    acc_addr_s   = addr_r;
    acc_wdata_s  = wdata_r;
    acc_size_s   = size_r;
    acc_sext_s   = sext_r;
    acc_write_s  = write_op_r;
    enter_done_s = 1'b0;
    if (state_r == ST_IDLE) begin
      acc_addr_s  = bus.address[AW+1:0];
      acc_wdata_s = bus.write_data;
      acc_size_s  = bus.size;
      acc_sext_s  = bus.sign_ext;
      acc_write_s = bus.MemWrite;
    end else begin
      acc_addr_s  = addr_r;
    end
    case (state_r)
      ST_IDLE: enter_done_s = req_s && (WAIT_STATES == 0);
      ST_WAIT: enter_done_s = (wait_cnt_r == 4'd0);
      default: enter_done_s = 1'b0;
    endcase
  end

  assign misaligned_s = is_misaligned(acc_addr_s[1:0], acc_size_s);
  assign idx_s        = acc_addr_s[AW+1:2];
  assign mem_word_s   = mem_r[idx_s];
  assign load_val_s   = load_extract(mem_word_s, acc_addr_s[1:0], acc_size_s, acc_sext_s);
  assign store_word_s = store_merge(mem_word_s, acc_wdata_s, acc_addr_s[1:0], acc_size_s);
  assign commit_s     = enter_done_s & acc_write_s & ~misaligned_s;

  // Access sequencer: IDLE samples a request, WAIT burns wait states, DONE lasts one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      size_r     <= 2'b00;
      sext_r     <= 1'b0;
      write_op_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            addr_r     <= bus.address[AW+1:0];
            wdata_r    <= bus.write_data;
            size_r     <= bus.size;
            sext_r     <= bus.sign_ext;
            write_op_r <= bus.MemWrite;
            wait_cnt_r <= WAIT_LOAD;
            state_r    <= (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Result registers update on the edge entering DONE so they are valid alongside ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_r  <= 32'd0;
      ready_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      ready_r      <= enter_done_s;
      misaligned_r <= enter_done_s & misaligned_s;
      if (enter_done_s && misaligned_s) begin
        read_data_r <= 32'd0;
      end else if (enter_done_s && !acc_write_s) begin
        read_data_r <= load_val_s;
      end
    end
  end

  // Storage array is never cleared; a store commits only on the DONE-entry edge.
  always_ff @(posedge clock) begin
    if (commit_s && !reset) begin
      mem_r[idx_s] <= store_word_s;
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] read_count_r;
  logic [15:0] write_count_r;

  // Saturating counters of aligned completions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_count_r  <= 16'd0;
      write_count_r <= 16'd0;
    end else if (enter_done_s && !misaligned_s) begin
      if (acc_write_s) begin
        if (write_count_r != 16'hFFFF) write_count_r <= write_count_r + 16'd1;
      end else begin
        if (read_count_r != 16'hFFFF) read_count_r <= read_count_r + 16'd1;
      end
    end
  end

  assign bus.read_count  = read_count_r;
  assign bus.write_count = write_count_r;
`else
  assign bus.read_count  = 16'd0;
  assign bus.write_count = 16'd0;
`endif

  assign bus.read_data  = read_data_r;
  assign bus.ready      = ready_r;
  assign bus.misaligned = misaligned_r;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: byte-addressed reference model plus a per-cycle compare process.
// Covers both the default build and DMEM_ACCESS_COUNT_EN.
module tb_data_memory_sized;
  localparam int WS    = 1;
  localparam int DEPTH = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_sized_if bus ();
  data_memory_sized_if bus0 ();

  data_memory_sized #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  data_memory_sized #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int due      = -1;
  int exp_reads  = 0;
  int exp_writes = 0;
  logic [7:0]  mb [DEPTH*4];
  logic [31:0] exp_rd  = 32'd0;
  logic [31:0] pend_rd = 32'd0;
  logic        pend_mis = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_mis(input logic [31:0] addr, input logic [1:0] sz);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
  endfunction

  function automatic int byte_index(input logic [31:0] addr);
    return int'(addr % 32'(DEPTH*4));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic sx);
    int a = byte_index(addr);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = {24'd0, mb[a]};
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'd0, mb[a+1], mb[a]};
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    int a = byte_index(addr);
    int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[a+i] = data[8*i +: 8];
  endtask

  // Every non-reset cycle: ready only in the predicted cycle, results match the model, read_data otherwise held.
  always @(negedge clock) begin
    if (!reset) begin
      if (cyc == due) begin
        check("ready_pulse", {31'd0, bus.ready}, 32'd1);
        check("misaligned_done", {31'd0, bus.misaligned}, {31'd0, pend_mis});
        check("read_data_done", bus.read_data, pend_rd);
        exp_rd = pend_rd;
      end else begin
        check("ready_quiet", {31'd0, bus.ready}, 32'd0);
        check("misaligned_quiet", {31'd0, bus.misaligned}, 32'd0);
        check("read_data_hold", bus.read_data, exp_rd);
      end
    end
  end

  task automatic check_counts(input string name);
`ifdef DMEM_ACCESS_COUNT_EN
    check({name, "_rdcnt"}, {16'd0, bus.read_count}, 32'(exp_reads));
    check({name, "_wrcnt"}, {16'd0, bus.write_count}, 32'(exp_writes));
`else
    check({name, "_rdcnt"}, {16'd0, bus.read_count}, 32'd0);
    check({name, "_wrcnt"}, {16'd0, bus.write_count}, 32'd0);
`endif
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] sz, input logic sx,
                        output logic [31:0] got, output logic got_mis);
    bit mis;
    bit seen = 1'b0;
    @(negedge clock);
    mis      = model_mis(addr, sz);
    pend_mis = mis;
    pend_rd  = mis ? 32'd0 : (wr ? exp_rd : model_load(addr, sz, sx));
    due      = cyc + 1 + WS;
    bus.address = addr; bus.write_data = data; bus.size = sz; bus.sign_ext = sx;
    bus.MemWrite = wr; bus.MemRead = !wr;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (bus.ready) seen = 1'b1;
    end
    got     = bus.read_data;
    got_mis = bus.misaligned;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    check("ready_seen", {31'd0, seen}, 32'd1);
    if (!mis) begin
      if (wr) begin
        model_store(addr, data, sz);
        exp_writes++;
      end else begin
        exp_reads++;
      end
    end
    check_counts("post_access");
  endtask

  task automatic access0(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] got, output int lat);
    bit seen = 1'b0;
    lat = 0;
    @(negedge clock);
    bus0.address = addr; bus0.write_data = data; bus0.size = 2'b10; bus0.sign_ext = 1'b0;
    bus0.MemWrite = wr; bus0.MemRead = !wr;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if (bus0.ready) seen = 1'b1;
    end
    got = bus0.read_data;
    bus0.MemWrite = 1'b0; bus0.MemRead = 1'b0;
  endtask

  logic [31:0] got;
  logic        got_mis;
  int          lat;

  initial begin
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'd0;
    bus.address = 32'd0; bus.write_data = 32'd0; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    bus0.address = 32'd0; bus0.write_data = 32'd0; bus0.size = 2'b10; bus0.sign_ext = 1'b0;
    bus0.MemWrite = 1'b0; bus0.MemRead = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("reset_read_data", bus.read_data, 32'd0);
    check("reset_ready", {31'd0, bus.ready}, 32'd0);
    check("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);
    check_counts("reset");

    access(1'b1, 32'h0, 32'h0000_000A, 2'b10, 1'b0, got, got_mis);
    access(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw0", got, 32'h0000_000A);

    access(1'b1, 32'h8, 32'h1122_3344, 2'b10, 1'b0, got, got_mis);
    access(1'b1, 32'h9, 32'h0000_00AB, 2'b00, 1'b0, got, got_mis);
    access(1'b0, 32'h8, 32'h0, 2'b10, 1'b1, got, got_mis);
    check("lw8_after_sb", got, 32'h1122_AB44);
    access(1'b0, 32'h9, 32'h0, 2'b00, 1'b1, got, got_mis);
    check("lb9", got, 32'hFFFF_FFAB);
    access(1'b0, 32'h9, 32'h0, 2'b00, 1'b0, got, got_mis);
    check("lbu9", got, 32'h0000_00AB);
    access(1'b1, 32'hB, 32'hFFFF_FF77, 2'b00, 1'b0, got, got_mis);
    access(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw8_after_sb_lane3", got, 32'h7722_AB44);

    access(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, got, got_mis);
    access(1'b1, 32'h12, 32'h1234_8001, 2'b01, 1'b0, got, got_mis);
    access(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, got, got_mis);
    check("lh12", got, 32'hFFFF_8001);
    access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, got, got_mis);
    check("lhu12", got, 32'h0000_8001);
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw10", got, 32'h8001_0000);

    access(1'b0, 32'h2, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw2_data", got, 32'h0);
    check("lw2_mis", {31'd0, got_mis}, 32'd1);
    access(1'b1, 32'h3, 32'hFFFF_FFFF, 2'b01, 1'b0, got, got_mis);
    check("sh3_mis", {31'd0, got_mis}, 32'd1);
    access(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw0_unchanged", got, 32'h0000_000A);

    access(1'b1, 32'h400, 32'h5A5A_5A5A, 2'b10, 1'b0, got, got_mis);
    access(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw0_wrap", got, 32'h5A5A_5A5A);
    access(1'b0, 32'h400, 32'h0, 2'b11, 1'b1, got, got_mis);
    check("size11_word", got, 32'h5A5A_5A5A);

    // Store aborted by reset while in its wait state.
    access(1'b1, 32'h4, 32'h0102_0304, 2'b10, 1'b0, got, got_mis);
    @(negedge clock);
    bus.address = 32'h4; bus.write_data = 32'hDEAD_BEEF; bus.size = 2'b10; bus.MemWrite = 1'b1;
    @(negedge clock);
    #1 reset = 1'b1;
    due = -1; exp_rd = 32'd0; exp_reads = 0; exp_writes = 0;
    bus.MemWrite = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_no_ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("abort_read_data", bus.read_data, 32'd0);
    check_counts("abort");
    access(1'b0, 32'h4, 32'h0, 2'b10, 1'b0, got, got_mis);
    check("lw4_after_abort", got, 32'h0102_0304);

    access0(1'b1, 32'h20, 32'hCAFE_F00D, got, lat);
    check("ws0_store_latency", 32'(lat), 32'd1);
    access0(1'b0, 32'h20, 32'h0, got, lat);
    check("ws0_load_latency", 32'(lat), 32'd1);
    check("ws0_load_data", got, 32'hCAFE_F00D);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
